// File: rtl/sync_debounce_pkg.sv
// Shared types and constants for the CE-gated debounce controller.
package sync_debounce_pkg;

  // Per-channel debounce FSM state.
  typedef enum logic [1:0] {
    StableLo = 2'd0,
    PendHi   = 2'd1,
    StableHi = 2'd2,
    PendLo   = 2'd3
  } deb_state_e;

  localparam int unsigned DebounceDef = 4;
  localparam int unsigned DebounceMax = 255;
  localparam int unsigned GlitchCntW  = 8;

  // Width of the debounce counter; it must hold the value DEBOUNCE itself.
  function automatic int unsigned cnt_width(input int unsigned debounce);
    return $clog2(debounce + 1);
  endfunction

  localparam int unsigned CntWDef = $clog2(DebounceDef + 1);

endpackage

// File: rtl/sync_ce_debounce_ctrl_if.sv
// Status-input bus between the pad side and the debounce controller.
interface sync_ce_debounce_ctrl_if #(
  parameter int unsigned WIDTH = 1
) ();

  logic             enable;
  logic [WIDTH-1:0] raw_in;
  logic             ce_out;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;
  logic [7:0]       glitch_cnt;

  // Driver of the raw inputs (pads / testbench).
  modport master (
    output enable, raw_in,
    input  ce_out, state, rise, fall, changed, glitch_cnt
  );

  // The debounce controller.
  modport slave (
    input  enable, raw_in,
    output ce_out, state, rise, fall, changed, glitch_cnt
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: 4-state FSM plus run-length counter, advanced only on ce_i.
// state_o/rise_o/fall_o are registered; glitch_o flags an aborted pending transition
// in the ce cycle where it happens.
module debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ce_i,
  input  logic s3_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o
);

  localparam int unsigned     CntW    = cnt_width(DEBOUNCE);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  deb_state_e      st_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic            state_q;
  logic            rise_q;
  logic            fall_q;

  assign cnt_inc = cnt_q + CntOne;

  // Debounce FSM with registered level and edge pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= StableLo;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (ce_i) begin
        unique case (st_q)
          StableLo: begin
            if (s3_i) begin
              if (DEBOUNCE == 1) begin
                st_q    <= StableHi;
                cnt_q   <= '0;
                state_q <= 1'b1;
                rise_q  <= 1'b1;
              end else begin
                st_q  <= PendHi;
                cnt_q <= CntOne;
              end
            end
          end
          PendHi: begin
            if (s3_i) begin
              if (cnt_inc == CntLast) begin
                st_q    <= StableHi;
                cnt_q   <= '0;
                state_q <= 1'b1;
                rise_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              st_q  <= StableLo;
              cnt_q <= '0;
            end
          end
          StableHi: begin
            if (!s3_i) begin
              if (DEBOUNCE == 1) begin
                st_q    <= StableLo;
                cnt_q   <= '0;
                state_q <= 1'b0;
                fall_q  <= 1'b1;
              end else begin
                st_q  <= PendLo;
                cnt_q <= CntOne;
              end
            end
          end
          PendLo: begin
            if (!s3_i) begin
              if (cnt_inc == CntLast) begin
                st_q    <= StableLo;
                cnt_q   <= '0;
                state_q <= 1'b0;
                fall_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              st_q  <= StableHi;
              cnt_q <= '0;
            end
          end
          default: begin
            st_q  <= StableLo;
            cnt_q <= '0;
          end
        endcase
      end
    end
  end

  // A pending transition is abandoned when the sample reverts before acceptance.
  always_comb begin
    glitch_o = ce_i & (((st_q == PendHi) & ~s3_i) | ((st_q == PendLo) & s3_i));
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/sync_ce_debounce_ctrl.sv
// CE scheduler + debounce controller for slow asynchronous status inputs.
// Prescaler produces a CE strobe every CE_DIV clocks; inputs pass a 3-stage CE-gated
// synchronizer and then one debounce_channel each.
// Optional: define SYNC_DEBOUNCE_GLITCH_CNT_EN to build the saturating glitch counter;
// otherwise glitch_cnt reads 0.
module sync_ce_debounce_ctrl
  import sync_debounce_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CE_DIV   = 16,
  parameter int unsigned DEBOUNCE = DebounceDef
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  sync_ce_debounce_ctrl_if.slave bus
);

  localparam int unsigned     PreW    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CE_DIV - 1);
  localparam logic [PreW-1:0] PreOne  = PreW'(1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic             ce;
  logic             ce_out_q;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] state, rise, fall, glitch;

  // Prescaler next state and CE decode; disabled prescaler parks at 0.
  always_comb begin
    ce    = bus.enable && (pre_q == PreLast);
    pre_d = pre_q;
    if (!bus.enable || ce) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PreOne;
    end
  end

  // Prescaler counter and registered CE copy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q    <= '0;
      ce_out_q <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      ce_out_q <= ce;
    end
  end

  // CE-gated three-stage synchronizer; holds when no CE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (ce) begin
      s1_q <= bus.raw_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE (DEBOUNCE)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .ce_i     (ce),
      .s3_i     (s3_q[i]),
      .state_o  (state[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i]),
      .glitch_o (glitch[i])
    );
  end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [GlitchCntW-1:0] glitch_cnt_q;

  // Saturating count of cycles with at least one aborted transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      glitch_cnt_q <= '0;
    end else if ((|glitch) && (glitch_cnt_q != '1)) begin
      glitch_cnt_q <= glitch_cnt_q + GlitchCntW'(1);
    end
  end

  assign bus.glitch_cnt = glitch_cnt_q;
`else
  logic unused_glitch;
  assign unused_glitch  = |glitch;
  assign bus.glitch_cnt = 8'd0;
`endif

  assign bus.ce_out  = ce_out_q;
  assign bus.state   = state;
  assign bus.rise    = rise;
  assign bus.fall    = fall;
  assign bus.changed = |(rise | fall);

endmodule
